// File: rtl/cpumc_arb.sv
// rtl/cpumc_arb.sv - CPU/hci owner arbiter for the cpumc bus
// Stalls the 6502 via rdy and waits for settled read cycles before handing the bus to hci.
module cpumc_arb #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int MIN_CPU_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        hci_req_in,
  input  logic [15:0] hci_a_in,
  input  logic        hci_r_nw_in,
  input  logic [7:0]  hci_d_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  output logic        cpu_rdy_out,
  output logic        hci_gnt_out,
  output logic [15:0] mc_a_out,
  output logic        mc_r_nw_out,
  output logic [7:0]  mc_d_out,
  output logic        mc_hci_sel_out
);

  typedef enum logic [1:0] {
    ST_CPU,
    ST_DRAIN,
    ST_HCI,
    ST_RELEASE
  } state_t;

  // Settle counter is 4 bits wide so the full SETTLE_CYCLES range fits.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TENURE_MAX  = 8'(MIN_CPU_CYCLES);
  localparam logic [7:0] TENURE_LAST = 8'(MIN_CPU_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [7:0]  tcnt_q, tcnt_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_CPU;
      scnt_q  <= 4'd0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      ST_CPU: begin
        if (tcnt_q < TENURE_MAX) tcnt_d = tcnt_q + 8'd1;
        if (hci_req_in && (tcnt_q >= TENURE_LAST)) begin
          state_d = ST_DRAIN;
          scnt_d  = 4'd0;
        end
      end
      ST_DRAIN: begin
        // The 6502 ignores rdy on writes, so only a run of reads proves it has stopped.
        if (!hci_req_in) begin
          state_d = ST_RELEASE;
        end else if (cpu_r_nw_in && (scnt_q == SETTLE_LAST)) begin
          state_d = ST_HCI;
        end else if (cpu_r_nw_in) begin
          scnt_d = scnt_q + 4'd1;
        end else begin
          scnt_d = 4'd0;
        end
      end
      ST_HCI: begin
        if (!hci_req_in) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_CPU;
        tcnt_d  = 8'd0;
      end
      default: state_d = ST_CPU;
    endcase
  end

  assign cpu_rdy_out    = (state_q == ST_CPU);
  assign hci_gnt_out    = (state_q == ST_HCI);
  assign mc_hci_sel_out = (state_q == ST_HCI);

  assign mc_a_out    = mc_hci_sel_out ? hci_a_in    : cpu_a_in;
  assign mc_r_nw_out = mc_hci_sel_out ? hci_r_nw_in : cpu_r_nw_in;
  assign mc_d_out    = mc_hci_sel_out ? hci_d_in    : cpu_d_in;

endmodule

// File: tb/tb_cpumc_arb.sv
// tb/tb_cpumc_arb.sv - directed self-checking bench for cpumc_arb
module tb_cpumc_arb;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        hci_req_in;
  logic [15:0] hci_a_in;
  logic        hci_r_nw_in;
  logic [7:0]  hci_d_in;
  logic [15:0] cpu_a_in;
  logic        cpu_r_nw_in;
  logic [7:0]  cpu_d_in;
  logic        cpu_rdy_out;
  logic        hci_gnt_out;
  logic [15:0] mc_a_out;
  logic        mc_r_nw_out;
  logic [7:0]  mc_d_out;
  logic        mc_hci_sel_out;

  int errors = 0;
  int checks = 0;

  cpumc_arb #(.SETTLE_CYCLES(2), .MIN_CPU_CYCLES(4)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .hci_req_in    (hci_req_in),
    .hci_a_in      (hci_a_in),
    .hci_r_nw_in   (hci_r_nw_in),
    .hci_d_in      (hci_d_in),
    .cpu_a_in      (cpu_a_in),
    .cpu_r_nw_in   (cpu_r_nw_in),
    .cpu_d_in      (cpu_d_in),
    .cpu_rdy_out   (cpu_rdy_out),
    .hci_gnt_out   (hci_gnt_out),
    .mc_a_out      (mc_a_out),
    .mc_r_nw_out   (mc_r_nw_out),
    .mc_d_out      (mc_d_out),
    .mc_hci_sel_out(mc_hci_sel_out)
  );

  always #5 clk_in = ~clk_in;

  // Grant and rdy must never overlap.
  always @(negedge clk_in) begin
    if (rst_in === 1'b0) begin
      checks++;
      if (hci_gnt_out === 1'b1 && cpu_rdy_out === 1'b1) begin
        errors++;
        $display("FAIL gnt_rdy_overlap: gnt=%b rdy=%b required not both 1", hci_gnt_out, cpu_rdy_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in      = 1'b1;
    hci_req_in  = 1'b1;
    cpu_a_in    = 16'hC000;
    cpu_r_nw_in = 1'b1;
    cpu_d_in    = 8'h11;
    hci_a_in    = 16'h1234;
    hci_r_nw_in = 1'b1;
    hci_d_in    = 8'h99;
    tick();
    tick();
    checks++;
    if (cpu_rdy_out !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", cpu_rdy_out); end
    checks++;
    if (hci_gnt_out !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", hci_gnt_out); end
    checks++;
    if (mc_hci_sel_out !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b want 0", mc_hci_sel_out); end
    checks++;
    if (mc_a_out !== 16'hC000) begin errors++; $display("FAIL reset_mc_a: got %h want c000", mc_a_out); end
    checks++;
    if (mc_d_out !== 8'h11) begin errors++; $display("FAIL reset_mc_d: got %h want 11", mc_d_out); end
    hci_req_in = 1'b0;
    rst_in     = 1'b0;
  endtask

  task automatic test_basic_grant();
    cpu_r_nw_in = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    hci_req_in = 1'b1;
    tick();
    checks++;
    if (cpu_rdy_out !== 1'b0) begin errors++; $display("FAIL grant_rdy_fall: got %b want 0", cpu_rdy_out); end
    checks++;
    if (hci_gnt_out !== 1'b0) begin errors++; $display("FAIL grant_early1: got %b want 0", hci_gnt_out); end
    tick();
    checks++;
    if (hci_gnt_out !== 1'b0) begin errors++; $display("FAIL grant_early2: got %b want 0", hci_gnt_out); end
    tick();
    checks++;
    if (hci_gnt_out !== 1'b1) begin errors++; $display("FAIL grant_rise: got %b want 1", hci_gnt_out); end
    checks++;
    if (mc_hci_sel_out !== 1'b1) begin errors++; $display("FAIL grant_sel: got %b want 1", mc_hci_sel_out); end
    hci_a_in    = 16'h0300;
    hci_r_nw_in = 1'b0;
    hci_d_in    = 8'h5A;
    cpu_a_in    = 16'hC123;
    #1;
    checks++;
    if (mc_a_out !== 16'h0300) begin errors++; $display("FAIL hci_mc_a: got %h want 0300", mc_a_out); end
    checks++;
    if (mc_r_nw_out !== 1'b0) begin errors++; $display("FAIL hci_mc_r_nw: got %b want 0", mc_r_nw_out); end
    checks++;
    if (mc_d_out !== 8'h5A) begin errors++; $display("FAIL hci_mc_d: got %h want 5a", mc_d_out); end
  endtask

  task automatic test_release_tenure();
    int rdy_cycles;
    hci_req_in = 1'b0;
    tick();
    checks++;
    if (hci_gnt_out !== 1'b0 || mc_hci_sel_out !== 1'b0) begin
      errors++;
      $display("FAIL release_gnt_sel: gnt=%b sel=%b want 0 0", hci_gnt_out, mc_hci_sel_out);
    end
    checks++;
    if (cpu_rdy_out !== 1'b0) begin errors++; $display("FAIL release_rdy_hold: got %b want 0", cpu_rdy_out); end
    checks++;
    if (mc_a_out !== 16'hC123) begin errors++; $display("FAIL release_mc_a: got %h want c123", mc_a_out); end
    hci_req_in = 1'b1;
    tick();
    checks++;
    if (cpu_rdy_out !== 1'b1) begin errors++; $display("FAIL release_rdy_rise: got %b want 1", cpu_rdy_out); end
    rdy_cycles = 0;
    for (int i = 0; i < 20 && cpu_rdy_out === 1'b1; i++) begin
      rdy_cycles++;
      tick();
    end
    checks++;
    if (rdy_cycles != 4) begin errors++; $display("FAIL tenure_len: got %0d cycles want 4", rdy_cycles); end
  endtask

  task automatic test_write_drain();
    logic [5:0] pat;
    int drain_len;
    pat = 6'b110001;
    drain_len = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_rdy_out === 1'b0 && hci_gnt_out === 1'b0) drain_len++;
      cpu_r_nw_in = pat[i];
      tick();
      checks++;
      if (hci_gnt_out !== (i == 5)) begin
        errors++;
        $display("FAIL drain_gnt_step%0d: got %b want %b", i, hci_gnt_out, (i == 5));
      end
    end
    checks++;
    if (drain_len != 6) begin errors++; $display("FAIL drain_len: got %0d want 6", drain_len); end
    cpu_r_nw_in = 1'b1;
  endtask

  task automatic test_abandoned();
    hci_req_in = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 6; i++) tick();
    cpu_r_nw_in = 1'b0;
    hci_req_in  = 1'b1;
    tick();
    checks++;
    if (cpu_rdy_out !== 1'b0 || hci_gnt_out !== 1'b0) begin
      errors++;
      $display("FAIL abandon_drain: rdy=%b gnt=%b want 0 0", cpu_rdy_out, hci_gnt_out);
    end
    hci_req_in = 1'b0;
    tick();
    checks++;
    if (cpu_rdy_out !== 1'b0 || hci_gnt_out !== 1'b0) begin
      errors++;
      $display("FAIL abandon_release: rdy=%b gnt=%b want 0 0", cpu_rdy_out, hci_gnt_out);
    end
    tick();
    checks++;
    if (cpu_rdy_out !== 1'b1 || hci_gnt_out !== 1'b0) begin
      errors++;
      $display("FAIL abandon_back: rdy=%b gnt=%b want 1 0", cpu_rdy_out, hci_gnt_out);
    end
    cpu_r_nw_in = 1'b1;
  endtask

  task automatic test_reset_mid_hci();
    int wait_cycles;
    int rdy_cycles;
    hci_req_in = 1'b1;
    wait_cycles = 0;
    while (hci_gnt_out !== 1'b1 && wait_cycles < 20) begin
      tick();
      wait_cycles++;
    end
    checks++;
    if (hci_gnt_out !== 1'b1) begin errors++; $display("FAIL rst_hci_reach: gnt=%b want 1 within 20 cycles", hci_gnt_out); end
    cpu_a_in = 16'hE000;
    hci_a_in = 16'h0400;
    rst_in   = 1'b1;
    tick();
    rst_in = 1'b0;
    checks++;
    if (hci_gnt_out !== 1'b0 || mc_hci_sel_out !== 1'b0 || cpu_rdy_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_hci_state: gnt=%b sel=%b rdy=%b want 0 0 1", hci_gnt_out, mc_hci_sel_out, cpu_rdy_out);
    end
    checks++;
    if (mc_a_out !== 16'hE000) begin errors++; $display("FAIL rst_hci_mc_a: got %h want e000", mc_a_out); end
    rdy_cycles = 0;
    for (int i = 0; i < 20 && cpu_rdy_out === 1'b1; i++) begin
      rdy_cycles++;
      tick();
    end
    checks++;
    if (rdy_cycles != 4) begin errors++; $display("FAIL rst_tenure_len: got %0d cycles want 4", rdy_cycles); end
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_release_tenure();
    test_write_drain();
    test_abandoned();
    test_reset_mid_hci();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
